// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer: FSM state codes,
// the per-stage load-enable bundle and the hard-wired zero register index.
package pipe_pkg;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } pipe_state_e;

    localparam logic [1:0] ST_BOOT     = BOOT;
    localparam logic [1:0] ST_RUN      = RUN;
    localparam logic [1:0] ST_MEM_WAIT = MEM_WAIT;

    typedef struct packed {
        logic pc;
        logic if_id;
        logic id_exe;
        logic exe_mem;
        logic mem_wb;
    } stage_en_t;

    localparam stage_en_t EN_NONE = 5'b00000;
    localparam stage_en_t EN_ALL  = 5'b11111;
    // ID/EXE still loads (a bubble) and everything downstream keeps moving.
    localparam stage_en_t EN_HOLD_FRONT = 5'b00111;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Dependency detector for one producer stage: flags when that stage will write
// a non-zero register that the instruction in ID actually reads.
module hazard_cmp
    import pipe_pkg::*;
(
    input  logic [4:0] rd,
    input  logic       reg_write,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       rs1_used,
    input  logic       rs2_used,
    output logic       match
);

    assign match = reg_write && (rd != REG_ZERO) &&
                   ((rs1_used && (rd == rs1)) || (rs2_used && (rd == rs2)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: boot freeze, data-memory wait, branch squash and RAW stall.
// Define HAZ_FORWARD_EN when the EXE/MEM forwarding network is present.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int BOOT_CYCLES = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             rs1_used_id,
    input  logic             rs2_used_id,
    input  logic [4:0]       rd_exe,
    input  logic [4:0]       rd_mem,
    input  logic [4:0]       rd_wb,
    input  logic             reg_write_exe,
    input  logic             reg_write_mem,
    input  logic             reg_write_wb,
    input  logic             mem_read_exe,
    input  logic             branch_taken_exe,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_exe_en,
    output logic             exe_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_exe_flush,
    output logic             pc_redirect,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             busy
);

    localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

    logic [1:0]       state_q, state_d;
    logic [BW-1:0]    boot_cnt_q, boot_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             busy_q;
    logic             stall_inc, flush_inc, run_eval, hazard;
    stage_en_t        en;

    // Producer stages in order EXE, MEM, WB.
    logic [4:0] rd_stage [3];
    logic [2:0] wr_stage;
    logic [2:0] match_stage;

    assign rd_stage[0] = rd_exe;
    assign rd_stage[1] = rd_mem;
    assign rd_stage[2] = rd_wb;
    assign wr_stage    = {reg_write_wb, reg_write_mem, reg_write_exe};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cmp
            hazard_cmp u_cmp (
                .rd        (rd_stage[gi]),
                .reg_write (wr_stage[gi]),
                .rs1       (rs1_id),
                .rs2       (rs2_id),
                .rs1_used  (rs1_used_id),
                .rs2_used  (rs2_used_id),
                .match     (match_stage[gi])
            );
        end
    endgenerate

`ifdef HAZ_FORWARD_EN
    // Only a load in EXE cannot be forwarded in time.
    assign hazard = mem_read_exe && match_stage[0];
    logic [1:0] unused_match;
    assign unused_match = match_stage[2:1];
`else
    assign hazard = |match_stage;
    logic unused_mem_read;
    assign unused_mem_read = mem_read_exe;
`endif

    always_comb begin
        en           = EN_NONE;
        if_id_flush  = 1'b1;
        id_exe_flush = 1'b1;
        pc_redirect  = 1'b0;
        state_d      = state_q;
        boot_cnt_d   = boot_cnt_q;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        run_eval     = 1'b0;

        case (state_q)
            ST_BOOT: begin
                if (boot_cnt_q == '0) state_d = ST_RUN;
                else                  boot_cnt_d = boot_cnt_q - 1'b1;
            end
            ST_MEM_WAIT: begin
                if_id_flush  = 1'b0;
                id_exe_flush = 1'b0;
                if (dmem_ready) begin
                    state_d  = ST_RUN;
                    run_eval = 1'b1;
                end else begin
                    stall_inc = 1'b1;
                end
            end
            ST_RUN:  run_eval = 1'b1;
            default: state_d = ST_BOOT;
        endcase

        // The ready cycle out of MEM_WAIT shares this path with RUN.
        if (run_eval) begin
            if_id_flush  = 1'b0;
            id_exe_flush = 1'b0;
            if (dmem_req && !dmem_ready) begin
                stall_inc = 1'b1;
                state_d   = ST_MEM_WAIT;
            end else if (branch_taken_exe) begin
                en           = EN_ALL;
                pc_redirect  = 1'b1;
                if_id_flush  = 1'b1;
                id_exe_flush = 1'b1;
                flush_inc    = 1'b1;
            end else if (hazard) begin
                en           = EN_HOLD_FRONT;
                id_exe_flush = 1'b1;
                stall_inc    = 1'b1;
            end else begin
                en = EN_ALL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_BOOT;
            boot_cnt_q  <= BW'(BOOT_CYCLES - 1);
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            stall_cnt_q <= stall_cnt_q + CNT_W'(stall_inc);
            flush_cnt_q <= flush_cnt_q + CNT_W'(flush_inc);
            busy_q      <= (state_d != ST_RUN);
        end
    end

    assign pc_en      = en.pc;
    assign if_id_en   = en.if_id;
    assign id_exe_en  = en.id_exe;
    assign exe_mem_en = en.exe_mem;
    assign mem_wb_en  = en.mem_wb;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, corner sequences and
// randomized traffic against a cycle-level reference model of the sequencer.
module tb_pipe_hazard_ctrl;

    localparam int BOOT_CYCLES = 4;
    localparam int CNT_W       = 32;

    // {pc, if_id, id_exe, exe_mem, mem_wb, if_id_flush, id_exe_flush, pc_redirect}
    localparam logic [7:0] C_BOOT = 8'b00000_110;
    localparam logic [7:0] C_NORM = 8'b11111_000;
    localparam logic [7:0] C_HAZ  = 8'b00111_010;
    localparam logic [7:0] C_BR   = 8'b11111_111;
    localparam logic [7:0] C_MEMW = 8'b00000_000;
`ifdef HAZ_FORWARD_EN
    localparam logic [7:0] C_FWD  = C_NORM;
    localparam int LU_STALLS = 1;
`else
    localparam logic [7:0] C_FWD  = C_HAZ;
    localparam int LU_STALLS = 3;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [4:0] rs1_id, rs2_id, rd_exe, rd_mem, rd_wb;
    logic rs1_used_id, rs2_used_id, reg_write_exe, reg_write_mem, reg_write_wb;
    logic mem_read_exe, branch_taken_exe, dmem_req, dmem_ready;
    logic pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en;
    logic if_id_flush, id_exe_flush, pc_redirect, busy;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [7:0] dut_ctl;

    assign dut_ctl = {pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en,
                      if_id_flush, id_exe_flush, pc_redirect};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .rd_exe(rd_exe), .rd_mem(rd_mem), .rd_wb(rd_wb),
        .reg_write_exe(reg_write_exe), .reg_write_mem(reg_write_mem),
        .reg_write_wb(reg_write_wb), .mem_read_exe(mem_read_exe),
        .branch_taken_exe(branch_taken_exe),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_exe_en(id_exe_en),
        .exe_mem_en(exe_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_exe_flush(id_exe_flush),
        .pc_redirect(pc_redirect), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // Reference model: cycles of boot left, whether a memory access is pending.
    int               m_boot;
    bit               m_wait;
    bit               m_busy;
    logic [CNT_W-1:0] m_stall, m_flush;

    logic [7:0]       s_ctl;
    logic             s_busy;
    logic [CNT_W-1:0] s_stall, s_flush;

    typedef struct {
        string      name;
        logic [4:0] rs1, rs2, rde, rdm, rdw;
        logic       u1, u2, we, wm, ww, ld, br;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit dep(input logic [4:0] rd, input logic we);
        return we && rd != 0 &&
               ((rs1_used_id && rs1_id == rd) || (rs2_used_id && rs2_id == rd));
    endfunction

    function automatic bit m_haz();
`ifdef HAZ_FORWARD_EN
        return mem_read_exe && dep(rd_exe, reg_write_exe);
`else
        return dep(rd_exe, reg_write_exe) || dep(rd_mem, reg_write_mem) ||
               dep(rd_wb, reg_write_wb);
`endif
    endfunction

    function automatic logic [7:0] m_ctl();
        if (m_boot > 0)                             return C_BOOT;
        if (!dmem_ready && (m_wait || dmem_req))    return C_MEMW;
        if (branch_taken_exe)                       return C_BR;
        if (m_haz())                                return C_HAZ;
        return C_NORM;
    endfunction

    task automatic m_advance();
        if (m_boot > 0) begin
            m_boot--;
        end else if (!dmem_ready && (m_wait || dmem_req)) begin
            m_stall++;
            m_wait = 1'b1;
        end else begin
            m_wait = 1'b0;
            if (branch_taken_exe) m_flush++;
            else if (m_haz())     m_stall++;
        end
        m_busy = (m_boot > 0) || m_wait;
    endtask

    task automatic idle();
        rs1_id = 0; rs2_id = 0; rs1_used_id = 0; rs2_used_id = 0;
        rd_exe = 0; rd_mem = 0; rd_wb = 0;
        reg_write_exe = 0; reg_write_mem = 0; reg_write_wb = 0;
        mem_read_exe = 0; branch_taken_exe = 0; dmem_req = 0; dmem_ready = 1;
    endtask

    // One clock: sample on the falling edge, check against the model, advance.
    task automatic step();
        @(negedge clk);
        s_ctl = dut_ctl; s_busy = busy; s_stall = stall_cnt; s_flush = flush_cnt;
        $display("txn %0d rs1=%0d/%b rs2=%0d/%b rd=%0d/%0d/%0d we=%b%b%b ld=%b br=%b req=%b rdy=%b ctl=%b busy=%b stall=%0d flush=%0d",
                 txn, rs1_id, rs1_used_id, rs2_id, rs2_used_id, rd_exe, rd_mem, rd_wb,
                 reg_write_exe, reg_write_mem, reg_write_wb, mem_read_exe,
                 branch_taken_exe, dmem_req, dmem_ready, s_ctl, s_busy, s_stall, s_flush);
        txn++;
        chk("model_ctl", 64'(s_ctl), 64'(m_ctl()));
        chk("model_busy", 64'(s_busy), 64'(m_busy));
        chk("model_stall_cnt", 64'(s_stall), 64'(m_stall));
        chk("model_flush_cnt", 64'(s_flush), 64'(m_flush));
        m_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        #2;
        chk("reset_ctl", 64'(dut_ctl), 64'(C_BOOT));
        chk("reset_busy", 64'(busy), 64'd1);
        chk("reset_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("reset_flush_cnt", 64'(flush_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_boot  = BOOT_CYCLES;
        m_wait  = 1'b0;
        m_busy  = 1'b1;
        m_stall = '0;
        m_flush = '0;
    endtask

    task automatic boot_out();
        for (int i = 0; i < BOOT_CYCLES; i++) begin
            idle();
            step();
        end
    endtask

    function automatic vec_t mk(input string name,
                                input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2,
                                input logic [4:0] rde, input logic we, input logic ld,
                                input logic [4:0] rdm, input logic wm,
                                input logic [4:0] rdw, input logic ww,
                                input logic br, input logic [7:0] exp);
        vec_t v;
        v.name = name; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.rde = rde; v.we = we; v.ld = ld; v.rdm = rdm; v.wm = wm;
        v.rdw = rdw; v.ww = ww; v.br = br; v.exp = exp;
        return v;
    endfunction

    initial begin
        idle();
        //                 name                 rs1 u1 rs2 u2 rde we ld rdm wm rdw ww br  expected
        vecs[0]  = mk("idle",                0, 0,  0, 0,  0, 0, 0,  0, 0,  0, 0, 0, C_NORM);
        vecs[1]  = mk("exe_load_rs1",        5, 1,  0, 0,  5, 1, 1,  0, 0,  0, 0, 0, C_HAZ);
        vecs[2]  = mk("exe_load_rs2",        1, 1,  7, 1,  7, 1, 1,  0, 0,  0, 0, 0, C_HAZ);
        vecs[3]  = mk("exe_load_rs_unused",  5, 0,  0, 0,  5, 1, 1,  0, 0,  0, 0, 0, C_NORM);
        vecs[4]  = mk("exe_no_write",        5, 1,  0, 0,  5, 0, 1,  0, 0,  0, 0, 0, C_NORM);
        vecs[5]  = mk("rd_zero_load",        0, 1,  0, 0,  0, 1, 1,  0, 0,  0, 0, 0, C_NORM);
        vecs[6]  = mk("exe_alu_match",       9, 1,  0, 0,  9, 1, 0,  0, 0,  0, 0, 0, C_FWD);
        vecs[7]  = mk("mem_match",           0, 0,  3, 1,  0, 0, 0,  3, 1,  0, 0, 0, C_FWD);
        vecs[8]  = mk("wb_match",           12, 1,  0, 0,  0, 0, 0,  0, 0, 12, 1, 0, C_FWD);
        vecs[9]  = mk("branch_with_hazard",  5, 1,  0, 0,  5, 1, 1,  0, 0,  0, 0, 1, C_BR);
        vecs[10] = mk("branch_only",         0, 0,  0, 0,  0, 0, 0,  0, 0,  0, 0, 1, C_BR);
        vecs[11] = mk("no_match",            4, 1,  8, 1,  6, 1, 1,  2, 1, 10, 1, 0, C_NORM);

        @(posedge clk);
        #1;
        do_reset();

        // Boot window: PC held for BOOT_CYCLES cycles, busy drops with the first advance.
        for (int i = 0; i <= BOOT_CYCLES + 1; i++) begin
            idle();
            step();
            chk("boot_pc_en", 64'(s_ctl[7]), 64'(i >= BOOT_CYCLES));
            chk("boot_busy", 64'(s_busy), 64'(i < BOOT_CYCLES));
        end

        foreach (vecs[i]) begin
            idle();
            rs1_id = vecs[i].rs1; rs1_used_id = vecs[i].u1;
            rs2_id = vecs[i].rs2; rs2_used_id = vecs[i].u2;
            rd_exe = vecs[i].rde; reg_write_exe = vecs[i].we; mem_read_exe = vecs[i].ld;
            rd_mem = vecs[i].rdm; reg_write_mem = vecs[i].wm;
            rd_wb  = vecs[i].rdw; reg_write_wb = vecs[i].ww;
            branch_taken_exe = vecs[i].br;
            step();
            chk(vecs[i].name, 64'(s_ctl), 64'(vecs[i].exp));
        end

        // Load-use dependency on r5 with counters starting from a fresh reset.
        do_reset();
        boot_out();
        idle();
        rs1_id = 5; rs1_used_id = 1;
`ifdef HAZ_FORWARD_EN
        rd_exe = 5; reg_write_exe = 1; mem_read_exe = 1;
        step();
        chk("lu_stall_exe", 64'(s_ctl), 64'(C_HAZ));
        rd_exe = 0; reg_write_exe = 0; mem_read_exe = 0; rd_mem = 5; reg_write_mem = 1;
        step();
        chk("lu_resume", 64'(s_ctl), 64'(C_NORM));
        chk("lu_stall_cnt", 64'(s_stall), 64'd1);
`else
        rd_exe = 5; reg_write_exe = 1;
        step();
        chk("raw_stall_exe", 64'(s_ctl), 64'(C_HAZ));
        rd_exe = 0; reg_write_exe = 0; rd_mem = 5; reg_write_mem = 1;
        step();
        chk("raw_stall_mem", 64'(s_ctl), 64'(C_HAZ));
        rd_mem = 0; reg_write_mem = 0; rd_wb = 5; reg_write_wb = 1;
        step();
        chk("raw_stall_wb", 64'(s_ctl), 64'(C_HAZ));
        rd_wb = 0; reg_write_wb = 0;
        step();
        chk("raw_resume", 64'(s_ctl), 64'(C_NORM));
        chk("raw_stall_cnt", 64'(s_stall), 64'd3);
`endif

        // Taken branch together with a load-use match: squash, no stall.
        idle();
        rs1_id = 5; rs1_used_id = 1; rd_exe = 5; reg_write_exe = 1; mem_read_exe = 1;
        branch_taken_exe = 1;
        step();
        chk("br_lu_ctl", 64'(s_ctl), 64'(C_BR));
        idle();
        step();
        chk("br_lu_flush_cnt", 64'(s_flush), 64'd1);
        chk("br_lu_stall_cnt", 64'(s_stall), 64'(LU_STALLS));

        // Data memory wait: ready low for 5 cycles, then the completing cycle.
        idle();
        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("memw_ctl", 64'(s_ctl), 64'(C_MEMW));
            if (i > 0) chk("memw_busy", 64'(s_busy), 64'd1);
        end
        dmem_ready = 1;
        step();
        chk("memw_ready_ctl", 64'(s_ctl), 64'(C_NORM));
        chk("memw_ready_busy", 64'(s_busy), 64'd1);
        idle();
        step();
        chk("memw_stall_cnt", 64'(s_stall), 64'(LU_STALLS + 5));
        chk("memw_after_busy", 64'(s_busy), 64'd0);

        // Reset in the middle of a memory wait: counters were non-zero.
        dmem_req = 1; dmem_ready = 0;
        step();
        step();
        do_reset();
        boot_out();

        for (int i = 0; i < 400; i++) begin
            rs1_id = 5'($urandom_range(0, 3)); rs2_id = 5'($urandom_range(0, 3));
            rs1_used_id = 1'($urandom_range(0, 1)); rs2_used_id = 1'($urandom_range(0, 1));
            rd_exe = 5'($urandom_range(0, 3)); rd_mem = 5'($urandom_range(0, 3));
            rd_wb = 5'($urandom_range(0, 3));
            reg_write_exe = 1'($urandom_range(0, 1)); reg_write_mem = 1'($urandom_range(0, 1));
            reg_write_wb = 1'($urandom_range(0, 1)); mem_read_exe = 1'($urandom_range(0, 1));
            branch_taken_exe = ($urandom_range(0, 5) == 0);
            dmem_req = ($urandom_range(0, 3) == 0);
            dmem_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0) do_reset();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
